// File: rtl/vec_tx_pingpong.sv
// vec_tx_pingpong: double-buffered vector transmitter, N signed T-bit words per vector, one word per handshake
//   clk, reset (sync, active-high) | in_valid/in_ready/in_data: producer word stream into the fill bank
//   out_valid/out_ready/out_data/out_last: word stream of complete vectors, out_last marks word N-1
module vec_tx_pingpong #(
  parameter int N = 2,
  parameter int T = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [T-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [T-1:0] out_data,
  output logic         out_last
);
  localparam int W = N > 1 ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);
  logic [T-1:0] mem [2][N];
  logic [1:0]   full;
  logic         wr_bank, rd_bank, wr_acc, rd_xfer;
  logic [W-1:0] wr_idx, rd_idx;
  always_comb begin
    in_ready  = !full[wr_bank];
    out_valid = full[rd_bank];
    out_data  = full[rd_bank] ? mem[rd_bank][rd_idx] : '0;
    out_last  = full[rd_bank] && rd_idx == LAST;
    wr_acc    = in_valid && !full[wr_bank];
    rd_xfer   = full[rd_bank] && out_ready;
  end
  always_ff @(posedge clk)
    if (wr_acc && !reset) mem[wr_bank][wr_idx] <= in_data;
  always_ff @(posedge clk)
    if (reset) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_idx  <= '0;
      rd_idx  <= '0;
    end else begin
      if (wr_acc) begin
        wr_idx <= wr_idx == LAST ? '0 : wr_idx + 1'b1;
        if (wr_idx == LAST) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= !wr_bank;
        end
      end
      if (rd_xfer) begin
        rd_idx <= rd_idx == LAST ? '0 : rd_idx + 1'b1;
        if (rd_idx == LAST) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= !rd_bank;
        end
      end
    end
endmodule

// File: tb/tb_vec_tx_pingpong.sv
// tb_vec_tx_pingpong: table vectors, hand sequences and a queue-based reference model for vec_tx_pingpong
module tb_vec_tx_pingpong;
  localparam int N = 2;
  typedef struct {
    bit rs, iv, or_, eir, eov, eol;
    logic [5:0] d, eod;
  } row_t;
  logic clk = 0, reset = 0;
  logic in_valid = 0, out_ready = 0, in_ready, out_valid, out_last;
  logic [5:0] in_data = 0, out_data;
  logic in_valid1 = 0, out_ready1 = 0, in_ready1, out_valid1, out_last1;
  logic [5:0] in_data1 = 0, out_data1;
  int total = 0, passed = 0;
  int got[$];
  logic [5:0] outq[$], part[$];
  always #5 clk = ~clk;
  vec_tx_pingpong #(.N(N), .T(6)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );
  vec_tx_pingpong #(.N(1), .T(6)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1), .out_last(out_last1)
  );
  function automatic row_t mk(bit rs, bit iv, bit r, int d, bit eir, bit eov, int eod, bit eol);
    row_t x;
    x.rs = rs; x.iv = iv; x.or_ = r; x.d = 6'(d);
    x.eir = eir; x.eov = eov; x.eod = 6'(eod); x.eol = eol;
    return x;
  endfunction
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask
  task automatic chkq(input string nm, input int exp[$]);
    chk({nm, " count"}, got.size(), exp.size());
    foreach (exp[i]) chk($sformatf("%s word%0d", nm, i), i < got.size() ? got[i] : -999, exp[i]);
    got.delete();
  endtask
  // Model: outq holds the remaining words of all complete, unsent vectors; part is the vector being filled.
  function automatic int m_nvec(); return (outq.size() + N - 1) / N; endfunction
  function automatic bit m_ir(); return m_nvec() < 2; endfunction
  function automatic bit m_ov(); return outq.size() > 0; endfunction
  function automatic int m_od(); return m_ov() ? int'($signed(outq[0])) : 0; endfunction
  function automatic bit m_ol(); return m_ov() && ((outq.size() - 1) % N == 0); endfunction
  task automatic mstep(input bit rs, input bit v, input bit r, input logic [5:0] d);
    bit acc;
    if (rs) begin
      outq.delete();
      part.delete();
      return;
    end
    acc = v && m_ir();
    if (m_ov() && r) void'(outq.pop_front());
    if (acc) begin
      part.push_back(d);
      if (part.size() == N) begin
        foreach (part[i]) outq.push_back(part[i]);
        part.delete();
      end
    end
  endtask
  task automatic drive(input bit rs, input bit v, input bit r, input logic [5:0] d);
    reset = rs; in_valid = v; out_ready = r; in_data = d;
    #4;
  endtask
  task automatic finish_cyc(input bit rs, input bit v, input bit r, input logic [5:0] d);
    if (!rs && out_valid && out_ready) got.push_back(int'($signed(out_data)));
    @(posedge clk);
    mstep(rs, v, r, d);
    #1;
  endtask
  task automatic cyc(input bit rs, input bit v, input bit r, input int d);
    drive(rs, v, r, 6'(d));
    chk("in_ready", in_ready, m_ir());
    chk("out_valid", out_valid, m_ov());
    chk("out_data", int'($signed(out_data)), m_od());
    chk("out_last", out_last, m_ol());
    finish_cyc(rs, v, r, 6'(d));
  endtask
  task automatic trow(input row_t x, input int k);
    drive(x.rs, x.iv, x.or_, x.d);
    chk($sformatf("row%0d in_ready", k), in_ready, x.eir);
    chk($sformatf("row%0d out_valid", k), out_valid, x.eov);
    chk($sformatf("row%0d out_data", k), int'($signed(out_data)), int'($signed(x.eod)));
    chk($sformatf("row%0d out_last", k), out_last, x.eol);
    finish_cyc(x.rs, x.iv, x.or_, x.d);
  endtask
  task automatic t1(input row_t x, input int k);
    in_valid1 = x.iv; out_ready1 = x.or_; in_data1 = x.d;
    #4;
    chk($sformatf("n1 row%0d in_ready", k), in_ready1, x.eir);
    chk($sformatf("n1 row%0d out_valid", k), out_valid1, x.eov);
    chk($sformatf("n1 row%0d out_data", k), int'($signed(out_data1)), int'($signed(x.eod)));
    chk($sformatf("n1 row%0d out_last", k), out_last1, x.eol);
    @(posedge clk);
    #1;
  endtask
  row_t tab[$], tab1[$];
  initial begin
    // reset, then test 1 and test 3 with hand-derived expectations
    tab.push_back(mk(1, 1, 1, 0, 1, 0, 0, 0));
    tab.push_back(mk(0, 1, 1, 5, 1, 0, 0, 0));
    tab.push_back(mk(0, 1, 1, -3, 1, 0, 0, 0));
    tab.push_back(mk(0, 0, 1, 0, 1, 1, 5, 0));
    tab.push_back(mk(0, 0, 1, 0, 1, 1, -3, 1));
    tab.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0));
    tab.push_back(mk(0, 1, 1, -32, 1, 0, 0, 0));
    tab.push_back(mk(0, 1, 1, 31, 1, 0, 0, 0));
    tab.push_back(mk(0, 1, 1, 0, 1, 1, -32, 0));
    tab.push_back(mk(0, 1, 1, -1, 1, 1, 31, 1));
    tab.push_back(mk(0, 1, 1, 10, 1, 1, 0, 0));
    tab.push_back(mk(0, 1, 1, -10, 1, 1, -1, 1));
    tab.push_back(mk(0, 0, 1, 0, 1, 1, 10, 0));
    tab.push_back(mk(0, 0, 1, 0, 1, 1, -10, 1));
    tab.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0));
    foreach (tab[i]) trow(tab[i], i);
    chkq("t1t3 order", '{5, -3, -32, 31, 0, -1, 10, -10});
    // test 2: both banks fill, 7 is held off until bank 0 drains
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 1); cyc(0, 1, 0, 2); cyc(0, 1, 0, 3); cyc(0, 1, 0, 4);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 6'd7);
      chk("both full in_ready", in_ready, 0);
      finish_cyc(0, 1, 0, 6'd7);
      mstep(0, 0, 0, 0);
    end
    cyc(0, 1, 1, 7); cyc(0, 1, 1, 7);
    drive(0, 1, 1, 6'd7);
    chk("bank0 released in_ready", in_ready, 1);
    finish_cyc(0, 1, 1, 6'd7);
    cyc(0, 0, 1, 0); cyc(0, 0, 1, 0);
    chkq("t2 order", '{1, 2, 3, 4});
    // test 4: toggling backpressure
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 9); cyc(0, 1, 0, -9);
    cyc(0, 0, 0, 0); cyc(0, 0, 1, 0); cyc(0, 0, 0, 0); cyc(0, 0, 1, 0); cyc(0, 0, 0, 0);
    chkq("t4 order", '{9, -9});
    // test 5: partial vector discarded by reset
    cyc(0, 1, 1, 6);
    cyc(1, 1, 1, 0);
    cyc(0, 1, 1, 2); cyc(0, 1, 1, 3);
    cyc(0, 0, 1, 0); cyc(0, 0, 1, 0); cyc(0, 0, 1, 0);
    chkq("t5 order", '{2, 3});
    // test 6: N=1 instance, main instance idle
    in_valid = 0; out_ready = 0;
    tab1.push_back(mk(0, 1, 1, -5, 1, 0, 0, 0));
    tab1.push_back(mk(0, 1, 1, 4, 1, 1, -5, 1));
    tab1.push_back(mk(0, 0, 1, 0, 1, 1, 4, 1));
    tab1.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0));
    tab1.push_back(mk(0, 1, 0, 11, 1, 0, 0, 0));
    tab1.push_back(mk(0, 1, 0, 12, 1, 1, 11, 1));
    tab1.push_back(mk(0, 1, 0, 13, 0, 1, 11, 1));
    tab1.push_back(mk(0, 0, 1, 0, 0, 1, 11, 1));
    tab1.push_back(mk(0, 0, 1, 0, 1, 1, 12, 1));
    foreach (tab1[i]) t1(tab1[i], i);
    // randomized traffic against the model
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
          int'($urandom_range(0, 63)));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
